// File: rtl/accum_12_bit.sv
// Frame accumulator: sums N unsigned 12-bit operands mod 4096 through one
// ripple adder, flags any carry out of bit 11, and holds the result until taken.
module add_12_bit (
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        cin,
  output logic [11:0] sum
);
  logic [11:0] c;

  assign c[0] = cin;

  // Carry out of bit 11 is dropped; the caller reconstructs it from the MSBs.
  for (genvar i = 0; i < 12; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    if (i < 11) begin : g_c
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
endmodule

module accum_12_bit #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_sum,
  output logic        ovf,
  output logic        busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [1:0]       state_q, state_d;
  logic [11:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [11:0]      acc_next;
  logic             carry;

  add_12_bit u_add (
    .a   (acc_q),
    .b   (in_data),
    .cin (1'b0),
    .sum (acc_next)
  );

  assign carry = (acc_q[11] & in_data[11]) | ((acc_q[11] | in_data[11]) & ~acc_next[11]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_d = acc_next;
          ovf_d = ovf_q | carry;
          // Counter parks at N-1 on the final accept.
          if (cnt_q == CNT_LAST) begin
            sum_d   = acc_next;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q == S_ACC) || (state_q == S_HOLD);
  assign out_sum   = sum_q;
  assign ovf       = ovf_q;
endmodule
